// File: rtl/sim_monitor_pkg.sv
// Shared types for the end-of-test monitor: status encoding, default tohost
// address and the store-log entry layout.
package sim_monitor_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_HALT    = 3'd3,
    ST_TIMEOUT = 3'd4
  } status_e;

  localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_0FFC;

  // Log entries hold 32-bit fields, so the monitor supports XLEN up to 32.
  localparam int ENTRY_W = 32;

  typedef struct packed {
    logic [ENTRY_W-1:0] addr;
    logic [ENTRY_W-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/store_log_buf.sv
// Circular buffer of recent stores with a saturating fill count and a
// newest-relative combinational read port (index 0 = most recent write).
module store_log_buf
  import sim_monitor_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  store_entry_t wr_entry,
  input  logic [AW-1:0] rd_idx,
  output store_entry_t rd_entry,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  store_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (we) begin
      wptr_d = wptr_q + AW'(1);
      if (count_q != FULL) count_d = count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage itself needs no reset: unfilled slots are masked by count_q.
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= wr_entry;
  end

  always_comb begin
    rd_ptr   = wptr_q - AW'(1) - rd_idx;
    rd_entry = '0;
    if ({1'b0, rd_idx} < count_q) rd_entry = mem[rd_ptr];
  end

  assign count = count_q;

endmodule

// File: rtl/sim_test_monitor.sv
// End-of-test monitor: snoops stores and retires, ends the run on a tohost
// write, a same-PC halt loop or a timeout, and keeps counters plus a store log.
module sim_test_monitor
  import sim_monitor_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_DEFAULT),
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HANG_CYCLES = 4,
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W = 32,
  localparam int LW = $clog2(LOG_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            retire,
  input  logic [XLEN-1:0] pc,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [LW-1:0]   log_idx,
  output logic [XLEN-1:0] log_addr,
  output logic [XLEN-1:0] log_data,
  output logic [LW:0]     log_count,
  output logic            done,
  output logic [2:0]      status,
  output logic [XLEN-1:0] fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic [CNT_W-1:0] store_count
);

  localparam int HW = $clog2(HANG_CYCLES + 1);
  localparam logic [HW-1:0] HANG_MAX = HW'(HANG_CYCLES);
  // Counter value before the retire that completes HANG_CYCLES same-PC retires.
  localparam logic [HW-1:0] HANG_LAST = HW'(HANG_CYCLES - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  status_e         state_q, state_d;
  logic [XLEN-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d, store_q, store_d;
  logic [HW-1:0]   hang_q, hang_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;

  logic running, tohost_hit, same_pc, halt_hit, timeout_hit, log_we;
  store_entry_t wr_entry, rd_entry;

  always_comb begin
    running     = (state_q == ST_RUN);
    tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    same_pc     = retire && (pc == last_pc_q);
    halt_hit    = same_pc && (hang_q == HANG_LAST);
    timeout_hit = (cycle_q == TIMEOUT_LAST);

    state_d   = state_q;
    fail_d    = fail_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    store_d   = store_q;
    hang_d    = hang_q;
    last_pc_d = last_pc_q;

    if (running) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (retire) instret_d = instret_q + CNT_W'(1);
      if (mem_we) store_d = store_q + CNT_W'(1);
      if (retire) begin
        last_pc_d = pc;
        if (!same_pc) hang_d = '0;
        else if (hang_q != HANG_MAX) hang_d = hang_q + HW'(1);
      end
      if (tohost_hit) begin
        if (mem_wdata == XLEN'(1)) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          fail_d  = mem_wdata >> 1;
        end
      end else if (halt_hit) begin
        state_d = ST_HALT;
      end else if (timeout_hit) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      fail_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      store_q   <= '0;
      hang_q    <= '0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      fail_q    <= fail_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      store_q   <= store_d;
      hang_q    <= hang_d;
      last_pc_q <= last_pc_d;
    end
  end

  always_comb begin
    log_we        = running && mem_we;
    wr_entry.addr = ENTRY_W'(mem_addr);
    wr_entry.data = ENTRY_W'(mem_wdata);
  end

  store_log_buf #(.DEPTH(LOG_DEPTH)) u_log (
    .clk      (clk),
    .reset    (reset),
    .we       (log_we),
    .wr_entry (wr_entry),
    .rd_idx   (log_idx),
    .rd_entry (rd_entry),
    .count    (log_count)
  );

  assign log_addr      = XLEN'(rd_entry.addr);
  assign log_data      = XLEN'(rd_entry.data);
  assign done          = (state_q != ST_RUN);
  assign status        = state_q;
  assign fail_code     = fail_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign store_count   = store_q;

endmodule

// File: tb/tb_sim_test_monitor.sv
// Bench for sim_test_monitor: directed scenarios with constant expectations
// plus randomized runs checked against a queue-based reference model.
module tb_sim_test_monitor;

  localparam int TMO   = 20;
  localparam int HANG  = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        reset, retire, mem_we;
  logic [31:0] pc, mem_addr, mem_wdata;
  logic [2:0]  log_idx;
  logic [31:0] log_addr, log_data, fail_code, cycle_count, instret_count, store_count;
  logic [3:0]  log_count;
  logic        done;
  logic [2:0]  status;

  int total = 0;
  int bad   = 0;

  // Reference model: state as plain ints, log and PC history as queues.
  int          m_state, m_cyc, m_inst, m_st;
  logic [31:0] m_fail;
  logic [31:0] m_addr_q[$];
  logic [31:0] m_data_q[$];
  logic [31:0] m_pcs[$];

  sim_test_monitor #(
    .XLEN(32), .TOHOST_ADDR(TOHOST), .TIMEOUT_CYCLES(TMO),
    .HANG_CYCLES(HANG), .LOG_DEPTH(DEPTH), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .retire(retire), .pc(pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .log_idx(log_idx),
    .log_addr(log_addr), .log_data(log_data), .log_count(log_count),
    .done(done), .status(status), .fail_code(fail_code),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_inst = 0; m_st = 0; m_fail = '0;
    m_addr_q.delete(); m_data_q.delete(); m_pcs.delete();
    m_pcs.push_back(32'h0);  // last_pc starts at 0 after reset
  endtask

  task automatic model_step(input logic r, input logic [31:0] p, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    int run;
    bit halt;
    logic [31:0] tmp;
    if (m_state != 0) return;
    m_cyc++;
    if (r) m_inst++;
    if (w) begin
      m_st++;
      m_addr_q.push_front(a);
      m_data_q.push_front(d);
      if (m_addr_q.size() > DEPTH) begin
        tmp = m_addr_q.pop_back();
        tmp = m_data_q.pop_back();
      end
    end
    halt = 1'b0;
    if (r) begin
      m_pcs.push_back(p);
      run = 0;
      for (int i = m_pcs.size() - 1; i >= 0; i--) begin
        if (m_pcs[i] != p) break;
        run++;
      end
      halt = (run >= HANG);
      if (m_pcs.size() > 2 * HANG) tmp = m_pcs.pop_front();
    end
    if (w && a == TOHOST) begin
      if (d == 32'd1) m_state = 1;
      else begin m_state = 2; m_fail = d >> 1; end
    end else if (halt) m_state = 3;
    else if (m_cyc == TMO) m_state = 4;
  endtask

  task automatic cyc(input logic r, input logic [31:0] p, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    retire = r; pc = p; mem_we = w; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    model_step(r, p, w, a, d);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; retire = 1'b0; mem_we = 1'b0; pc = '0; mem_addr = '0;
    mem_wdata = '0; log_idx = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; retire = 1'b0; mem_we = 1'b0; pc = '0; mem_addr = '0;
    mem_wdata = '0; log_idx = '0;
    @(posedge clk);
    #1;
    total++; if (status !== 3'd0) begin bad++; $display("FAIL reset_status: got %0d want 0", status); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if ({cycle_count, instret_count, store_count, fail_code} !== '0) begin
      bad++; $display("FAIL reset_counters: got %0h/%0h/%0h/%0h want 0", cycle_count, instret_count, store_count, fail_code);
    end
    total++; if ({log_count, log_addr, log_data} !== '0) begin
      bad++; $display("FAIL reset_log: got cnt=%0d addr=%0h data=%0h want 0", log_count, log_addr, log_data);
    end
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_pass();
    do_reset();
    cyc(1, 32'h0, 1, 32'h8, 32'd12);
    cyc(1, 32'h4, 0, 32'h0, 32'd0);
    cyc(0, 32'h0, 1, TOHOST, 32'd1);
    cyc(1, 32'h8, 1, 32'h40, 32'd9);
    log_idx = 3'd1; #1;
    total++; if (status !== 3'd1 || done !== 1'b1) begin bad++; $display("FAIL pass_status: got %0d/%0b want 1/1", status, done); end
    total++; if (log_addr !== 32'h8 || log_data !== 32'd12) begin bad++; $display("FAIL pass_log1: got %0h/%0d want 8/12", log_addr, log_data); end
    total++; if (store_count !== 32'd2) begin bad++; $display("FAIL pass_stores: got %0d want 2", store_count); end
  endtask

  task automatic test_fail();
    do_reset();
    cyc(1, 32'h0, 1, TOHOST, 32'd7);
    total++; if (status !== 3'd2 || fail_code !== 32'd3) begin bad++; $display("FAIL fail_code: got %0d/%0d want 2/3", status, fail_code); end
    cyc(1, 32'h4, 1, 32'h20, 32'd5);
    cyc(1, 32'h8, 1, TOHOST, 32'd1);
    log_idx = 3'd0; #1;
    total++; if (store_count !== 32'd1 || log_count !== 4'd1) begin bad++; $display("FAIL fail_frozen: got %0d/%0d want 1/1", store_count, log_count); end
    total++; if (log_addr !== TOHOST || log_data !== 32'd7 || status !== 3'd2) begin
      bad++; $display("FAIL fail_log0: got %0h/%0d st=%0d want ffc/7 st=2", log_addr, log_data, status);
    end
  endtask

  task automatic test_halt(input bit gap);
    logic [31:0] seq [7];
    seq = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h10, 32'h10, 32'h10};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (gap && i == 5) cyc(0, 32'h0, 0, 32'h0, 32'h0);
      cyc(1, seq[i], 0, 32'h0, 32'h0);
    end
    total++; if (status !== 3'd0) begin bad++; $display("FAIL halt_early gap=%0d: got %0d want 0", gap, status); end
    cyc(1, seq[6], 0, 32'h0, 32'h0);
    total++; if (status !== 3'd3 || instret_count !== 32'd7) begin
      bad++; $display("FAIL halt gap=%0d: got st=%0d inst=%0d want 3/7", gap, status, instret_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i < TMO; i++) cyc(1, 32'(4 * i), 0, 32'h0, 32'h0);
    total++; if (status !== 3'd0) begin bad++; $display("FAIL timeout_early: got %0d want 0", status); end
    cyc(1, 32'h400, 0, 32'h0, 32'h0);
    total++; if (status !== 3'd4 || cycle_count !== 32'd20) begin bad++; $display("FAIL timeout: got st=%0d cyc=%0d want 4/20", status, cycle_count); end
    cyc(1, 32'h404, 1, 32'h8, 32'h1);
    total++; if (cycle_count !== 32'd20 || store_count !== 32'd0) begin bad++; $display("FAIL timeout_frozen: got cyc=%0d st=%0d want 20/0", cycle_count, store_count); end
  endtask

  task automatic test_log_wrap();
    do_reset();
    for (int i = 1; i <= 10; i++) cyc(0, 32'h0, 1, 32'(32'h100 + 4 * i), 32'(i));
    log_idx = 3'd0; #1;
    total++; if (log_count !== 4'd8 || log_data !== 32'd10) begin bad++; $display("FAIL wrap_newest: got cnt=%0d data=%0d want 8/10", log_count, log_data); end
    log_idx = 3'd7; #1;
    total++; if (log_data !== 32'd3 || log_addr !== 32'h10c) begin bad++; $display("FAIL wrap_oldest: got %0h/%0d want 10c/3", log_addr, log_data); end
  endtask

  task automatic test_priority_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 32'h10, 0, 32'h0, 32'h0);
    cyc(1, 32'h10, 1, TOHOST, 32'd1);
    total++; if (status !== 3'd1) begin bad++; $display("FAIL prio_pass: got %0d want 1", status); end
    #3 reset = 1'b1;
    log_idx = 3'd0;
    #1;
    total++; if (status !== 3'd0 || done !== 1'b0 || fail_code !== 32'd0) begin bad++; $display("FAIL async_status: got %0d/%0b want 0/0", status, done); end
    total++; if ({cycle_count, instret_count, store_count} !== '0 || log_count !== 4'd0 || log_data !== 32'd0) begin
      bad++; $display("FAIL async_clear: got cyc=%0d inst=%0d st=%0d cnt=%0d", cycle_count, instret_count, store_count, log_count);
    end
  endtask

  task automatic test_random();
    logic        r, w;
    logic [31:0] p, a, d, last_p, ea, ed;
    int          idx;
    for (int run = 0; run < 40; run++) begin
      do_reset();
      last_p = 32'h0;
      for (int c = 0; c < 25; c++) begin
        r = ($urandom % 10) < 7;
        p = ($urandom % 2 == 0) ? last_p : 32'(4 * ($urandom % 4));
        w = ($urandom % 10) < 4;
        a = ($urandom % 20 == 0) ? TOHOST : (32'h8 << ($urandom % 3));
        d = ($urandom % 3 == 0) ? 32'd1 : 32'($urandom % 16);
        if (r) last_p = p;
        cyc(r, p, w, a, d);
        idx = int'($urandom % DEPTH);
        log_idx = 3'(idx);
        #1;
        ea = (idx < m_addr_q.size()) ? m_addr_q[idx] : 32'h0;
        ed = (idx < m_data_q.size()) ? m_data_q[idx] : 32'h0;
        total++; if (status !== 3'(m_state) || done !== (m_state != 0)) begin
          bad++; $display("FAIL rnd_status run=%0d c=%0d: got %0d/%0b want %0d", run, c, status, done, m_state);
        end
        total++; if (fail_code !== m_fail) begin bad++; $display("FAIL rnd_fail_code run=%0d c=%0d: got %0h want %0h", run, c, fail_code, m_fail); end
        total++; if (cycle_count !== 32'(m_cyc) || instret_count !== 32'(m_inst) || store_count !== 32'(m_st)) begin
          bad++; $display("FAIL rnd_counters run=%0d c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                          run, c, cycle_count, instret_count, store_count, m_cyc, m_inst, m_st);
        end
        total++; if (log_count !== 4'(m_addr_q.size())) begin bad++; $display("FAIL rnd_log_count run=%0d c=%0d: got %0d want %0d", run, c, log_count, m_addr_q.size()); end
        total++; if (log_addr !== ea || log_data !== ed) begin
          bad++; $display("FAIL rnd_log idx=%0d run=%0d c=%0d: got %0h/%0h want %0h/%0h", idx, run, c, log_addr, log_data, ea, ed);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_halt(1'b0);
    test_halt(1'b1);
    test_timeout();
    test_log_wrap();
    test_priority_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sim_test_monitor.md
Name: sim_test_monitor

Overview:
- Parametrised, reusable end-of-test monitor for the single-cycle core and its successors; replaces per-test hard-coded memory peeks and fixed cycle counts.
- Snoops the data-memory write port and the retire/PC stream.
- Detects a pass/fail write to a tohost address, a self-loop halt, or a timeout.
- Keeps cycle, instret and store counters plus a circular log of the most recent stores, so benches can check results without reaching into the hierarchy.

Parameters:
- XLEN, 32, data/PC width.
- TOHOST_ADDR, 32'h0000_0FFC, store address that ends the test.
- TIMEOUT_CYCLES, 1000, RUN cycles before TIMEOUT.
- HANG_CYCLES, 4, consecutive same-PC retires that count as a halt loop.
- LOG_DEPTH, 8, store-log entries; power of two, at least 2.
- CNT_W, 32, width of the counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- retire  in  1  one instruction retires this cycle
- pc  in  XLEN  PC of the retiring instruction, valid when retire=1
- mem_we  in  1  data-memory write strobe
- mem_addr  in  XLEN  write byte address
- mem_wdata  in  XLEN  write data
- log_idx  in  $clog2(LOG_DEPTH)  log read index; 0 = newest store
- log_addr  out  XLEN  address of the selected log entry
- log_data  out  XLEN  data of the selected log entry
- log_count  out  $clog2(LOG_DEPTH)+1  valid entries, saturates at LOG_DEPTH
- done  out  1  any terminal state reached
- status  out  3  RUN=0, PASS=1, FAIL=2, HALT=3, TIMEOUT=4
- fail_code  out  XLEN  mem_wdata>>1 captured on FAIL, else 0
- cycle_count  out  CNT_W  cycles spent in RUN
- instret_count  out  CNT_W  retires seen in RUN
- store_count  out  CNT_W  mem_we cycles seen in RUN, including the tohost store

Behaviour:
- Reset is asynchronous and active-high. Clock is clk, reset is reset.
- While reset=1 (including mid-run):
  - state=RUN, done=0, status=0, fail_code=0.
  - All counters 0, log_count=0, hang counter 0, last_pc 0.
  - Log contents don't-care; outputs are 0 while log_count=0.
- State machine: RUN is the only non-terminal state. Terminal states PASS, FAIL, HALT and TIMEOUT are sticky until reset.
- In a terminal state, counters, log, status and fail_code freeze, and inputs are ignored.
- done and status are registered: they update on the clock edge that samples the terminating event.
- Counters, evaluated per RUN cycle:
  - cycle_count += 1.
  - instret_count += retire.
  - store_count += mem_we.
  - All wrap modulo 2^CNT_W.
  - The terminating cycle is counted.
- Tohost store (mem_we=1 and mem_addr==TOHOST_ADDR):
  - mem_wdata==1 goes to PASS.
  - Any other value goes to FAIL, with fail_code=mem_wdata>>1.
  - A wdata of 0 is a FAIL with fail_code 0.
- Store log:
  - Every RUN-cycle store, tohost included, is written to a circular buffer. The write pointer wraps at LOG_DEPTH and the oldest entry is overwritten.
  - The read port is combinational: entry = (wptr-1-log_idx) mod LOG_DEPTH.
  - log_idx >= log_count returns 0 on both outputs.
- Hang detection:
  - On a retire with pc==last_pc, the hang counter increments, saturating at HANG_CYCLES.
  - On a retire with pc!=last_pc, the counter resets to 0.
  - Each retire loads last_pc. Non-retire cycles hold both the counter and last_pc.
  - HALT is entered when the counter reaches HANG_CYCLES-1 and the current retire has pc==last_pc, i.e. the HANG_CYCLES-th consecutive same-PC retire.
  - HALT is a clean stop, not a failure; benches inspect the log and counters.
- TIMEOUT is entered on the cycle where cycle_count would become TIMEOUT_CYCLES (the TIMEOUT_CYCLES-th RUN cycle).
- Priority when events coincide: tohost store > HALT > TIMEOUT.
- Simultaneous store and retire in one cycle are both recorded.

Decomposition:
- Package sim_monitor_pkg holds:
  - the status_e enum (RUN/PASS/FAIL/HALT/TIMEOUT, 3-bit);
  - TOHOST_DEFAULT;
  - a store_entry_t struct {addr, data}.
- One sub-module, store_log_buf: a parametrised circular buffer with write enable, wrapping pointer, saturating count and newest-relative read index.
- FSM, counters and hang detector stay in the top.

Test Plan:
- Store 12 to 0x8, then store 1 to TOHOST_ADDR, retires interleaved -> status=PASS, done=1; log_idx=1 gives addr 0x8 / data 12; store_count=2.
- Store 7 to TOHOST_ADDR -> status=FAIL, fail_code=3; further stores do not change store_count or the log.
- Retire pc 0x0,0x4,0x8, then pc 0x10 four times, HANG_CYCLES=4 -> HALT on the 4th 0x10 retire; instret_count=7. A variant with one non-retire cycle inside the 0x10 run still halts on the 4th 0x10 retire.
- No tohost store and distinct PCs, TIMEOUT_CYCLES=20 -> status=TIMEOUT exactly 20 cycles after reset release; cycle_count=20.
- Ten stores of data 1..10 with LOG_DEPTH=8 -> log_count=8, log_idx=0 gives data 10, log_idx=7 gives data 3.
- Tohost store of 1 in the same cycle as the 4th same-PC retire -> PASS wins. Then assert reset mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
